// File: rtl/wb_pkg.sv
// Shared types and constants for the register write-back queue.
package wb_pkg;

    localparam int unsigned REG_ADDR_W     = 3;
    localparam int unsigned DATA_W         = 16;
    localparam int unsigned NUM_REGS       = 1 << REG_ADDR_W;
    localparam int unsigned FLAGS_ADDR_DEF = 7;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
        logic [DATA_W-1:0]     flags;
        logic                  upd;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular entry store for reg_writeback; extra ports under REG_WRITEBACK_FWD_EN
// expose the contents for the forwarding lookup.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      Clk,
    input  logic      Reset_n,
    input  logic      push_i,
    input  wb_entry_t din_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
`ifdef REG_WRITEBACK_FWD_EN
    ,
    output logic [$clog2(DEPTH)-1:0]   rptr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output wb_entry_t [DEPTH-1:0]      mem_o
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rptr_q];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + PW'(1);
        if (do_pop)  rptr_d = rptr_q + PW'(1);
        if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
        if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

`ifdef REG_WRITEBACK_FWD_EN
    assign rptr_o  = rptr_q;
    assign count_o = cnt_q;
    assign mem_o   = mem_q;
`endif

endmodule

// File: rtl/reg_writeback.sv
// Register write-back queue: ALU/load arbitration, busy tracking and,
// with REG_WRITEBACK_FWD_EN defined, youngest-entry forwarding.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned FLAGS_ADDR = FLAGS_ADDR_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  AluValid,
    output logic                  AluReady,
    input  logic [REG_ADDR_W-1:0] AluAddr,
    input  logic [DATA_W-1:0]     AluData,
    input  logic [DATA_W-1:0]     AluFlags,
    input  logic                  AluUpdFlags,
    input  logic                  MemValid,
    output logic                  MemReady,
    input  logic [REG_ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0]     MemData,
    output logic                  WrEn,
    output logic [REG_ADDR_W-1:0] WrAddr,
    output logic [DATA_W-1:0]     WrData,
    output logic [DATA_W-1:0]     WrFlags,
    output logic                  WrUpdFlags,
    output logic [NUM_REGS-1:0]   Busy,
    input  logic [REG_ADDR_W-1:0] QueryAddr,
    output logic                  FwdHit,
    output logic [DATA_W-1:0]     FwdData
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [REG_ADDR_W-1:0] FA = REG_ADDR_W'(FLAGS_ADDR);

    wb_entry_t     push_e, head_e;
    logic          full, empty;
    logic          push, pop;
    logic [CW-1:0] cnt_q [NUM_REGS];
    logic [CW-1:0] cnt_d [NUM_REGS];
    logic [CW-1:0] flg_q, flg_d;

    // Loads win arbitration; ALU only sees ready when no load is offered.
    assign MemReady = !full;
    assign AluReady = !full && !MemValid;
    assign push     = (MemValid && MemReady) || (AluValid && AluReady);
    assign pop      = !empty;

    always_comb begin
        push_e = '{addr: AluAddr, data: AluData,
                   flags: AluFlags, upd: AluUpdFlags};
        if (MemValid) begin
            push_e = '{addr: MemAddr, data: MemData,
                       flags: '0, upd: 1'b0};
        end
    end

`ifdef REG_WRITEBACK_FWD_EN
    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0]         rptr;
    logic [CW-1:0]         count;
    wb_entry_t [DEPTH-1:0] ents;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .push_i  (push),
        .din_i   (push_e),
        .pop_i   (pop),
        .head_o  (head_e),
        .full_o  (full),
        .empty_o (empty),
        .rptr_o  (rptr),
        .count_o (count),
        .mem_o   (ents)
    );

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        FwdHit  = 1'b0;
        FwdData = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = rptr + PW'(i);
            if (i < int'(count)) begin
                if (QueryAddr == FA && ents[idx].upd) begin
                    FwdHit  = 1'b1;
                    FwdData = ents[idx].flags;
                end else if (ents[idx].addr == QueryAddr) begin
                    FwdHit  = 1'b1;
                    FwdData = ents[idx].data;
                end
            end
        end
    end
`else
    logic unused_query;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .push_i  (push),
        .din_i   (push_e),
        .pop_i   (pop),
        .head_o  (head_e),
        .full_o  (full),
        .empty_o (empty)
    );

    assign unused_query = ^QueryAddr;
    assign FwdHit       = 1'b0;
    assign FwdData      = '0;
`endif

    assign WrEn       = !empty;
    assign WrAddr     = head_e.addr;
    assign WrData     = head_e.data;
    assign WrFlags    = head_e.flags;
    assign WrUpdFlags = !empty && head_e.upd;

    always_comb begin
        flg_d = flg_q;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            cnt_d[i] = cnt_q[i];
            if (push && push_e.addr == REG_ADDR_W'(i))
                cnt_d[i] = cnt_d[i] + CW'(1);
            if (pop && head_e.addr == REG_ADDR_W'(i))
                cnt_d[i] = cnt_d[i] - CW'(1);
        end
        if (push && push_e.upd) flg_d = flg_d + CW'(1);
        if (pop && head_e.upd)  flg_d = flg_d - CW'(1);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt_q <= '{default: '0};
            flg_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            flg_q <= flg_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            Busy[i] = (cnt_q[i] != '0);
        end
        Busy[FA] = Busy[FA] | (flg_q != '0);
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Randomised scoreboard bench for reg_writeback.
module tb_reg_writeback;

    localparam int DEPTH = 4;
    localparam int FA    = 7;

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
        logic [15:0] f;
        logic        u;
    } ent_t;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        AluValid = 1'b0;
    logic        AluReady;
    logic [2:0]  AluAddr = '0;
    logic [15:0] AluData = '0;
    logic [15:0] AluFlags = '0;
    logic        AluUpdFlags = 1'b0;
    logic        MemValid = 1'b0;
    logic        MemReady;
    logic [2:0]  MemAddr = '0;
    logic [15:0] MemData = '0;
    logic        WrEn;
    logic [2:0]  WrAddr;
    logic [15:0] WrData;
    logic [15:0] WrFlags;
    logic        WrUpdFlags;
    logic [7:0]  Busy;
    logic [2:0]  QueryAddr = '0;
    logic        FwdHit;
    logic [15:0] FwdData;

    reg_writeback #(.DEPTH(DEPTH), .FLAGS_ADDR(FA)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .AluValid    (AluValid),
        .AluReady    (AluReady),
        .AluAddr     (AluAddr),
        .AluData     (AluData),
        .AluFlags    (AluFlags),
        .AluUpdFlags (AluUpdFlags),
        .MemValid    (MemValid),
        .MemReady    (MemReady),
        .MemAddr     (MemAddr),
        .MemData     (MemData),
        .WrEn        (WrEn),
        .WrAddr      (WrAddr),
        .WrData      (WrData),
        .WrFlags     (WrFlags),
        .WrUpdFlags  (WrUpdFlags),
        .Busy        (Busy),
        .QueryAddr   (QueryAddr),
        .FwdHit      (FwdHit),
        .FwdData     (FwdData)
    );

    always #5 Clk = ~Clk;

    ent_t mdl_q[$];
    ent_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    bit   started = 1'b0;
    bit   mem_acc = 1'b0;
    bit   alu_acc = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the queue holds every accepted, not yet written result.
    always @(posedge Clk) begin
        int   occ;
        ent_t e;
        mem_acc = 1'b0;
        alu_acc = 1'b0;
        started = 1'b1;
        e = '{3'd0, 16'h0, 16'h0, 1'b0};
        if (!Reset_n) begin
            mdl_q.delete();
            sb_q.delete();
        end else begin
            occ = mdl_q.size();
            if (occ > 0) void'(mdl_q.pop_front());
            if (occ < DEPTH && MemValid) begin
                e = '{MemAddr, MemData, 16'h0, 1'b0};
                mem_acc = 1'b1;
            end else if (occ < DEPTH && AluValid) begin
                e = '{AluAddr, AluData, AluFlags, AluUpdFlags};
                alu_acc = 1'b1;
            end
            if (mem_acc || alu_acc) begin
                mdl_q.push_back(e);
                sb_q.push_back(e);
            end
        end
    end

    // Monitor: compare everything the DUT presents against the model.
    always @(negedge Clk) begin
        int          n;
        logic [7:0]  busy;
        logic        hit;
        logic [15:0] fd;
        ent_t        h;
        if (started) begin
            n = mdl_q.size();
            chk("wren", WrEn, n != 0);
            chk("memready", MemReady, n < DEPTH);
            chk("aluready", AluReady, n < DEPTH && !MemValid);
            busy = '0;
            foreach (mdl_q[i]) begin
                busy[mdl_q[i].a] = 1'b1;
                if (mdl_q[i].u) busy[FA] = 1'b1;
            end
            chk("busy", Busy, busy);
            chk("wrupdflags", WrUpdFlags, n != 0 && mdl_q[0].u);
            hit = 1'b0;
            fd  = '0;
`ifdef REG_WRITEBACK_FWD_EN
            for (int i = 0; i < n; i++) begin
                if (int'(QueryAddr) == FA && mdl_q[i].u) begin
                    hit = 1'b1;
                    fd  = mdl_q[i].f;
                end else if (mdl_q[i].a == QueryAddr) begin
                    hit = 1'b1;
                    fd  = mdl_q[i].d;
                end
            end
`endif
            chk("fwdhit", FwdHit, hit);
            chk("fwddata", FwdData, fd);
            if (WrEn === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr %h data %h", WrAddr, WrData);
                end else begin
                    h = sb_q.pop_front();
                    chk("wraddr", WrAddr, h.a);
                    chk("wrdata", WrData, h.d);
                    if (h.u) chk("wrflags", WrFlags, h.f);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #2;
        if (mem_acc) MemValid = 1'b0;
        if (alu_acc) AluValid = 1'b0;
    endtask

    task automatic alu(logic [2:0] a, logic [15:0] d, logic [15:0] f, logic u);
        AluValid = 1'b1;
        AluAddr = a;
        AluData = d;
        AluFlags = f;
        AluUpdFlags = u;
    endtask

    task automatic mem(logic [2:0] a, logic [15:0] d);
        MemValid = 1'b1;
        MemAddr = a;
        MemData = d;
    endtask

    task automatic settle();
        int k = 0;
        while ((MemValid || AluValid) && k < 20) begin
            cyc();
            k++;
        end
        if (MemValid || AluValid) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout: mem %b alu %b", MemValid, AluValid);
            MemValid = 1'b0;
            AluValid = 1'b0;
        end
        repeat (3) cyc();
    endtask

    initial begin
        repeat (2) cyc();
        Reset_n = 1'b1;
        cyc();

        alu(3'd3, 16'h1234, 16'h0, 1'b0);
        settle();

        alu(3'd2, 16'h2222, 16'h0, 1'b0);
        mem(3'd5, 16'h5555);
        settle();

        alu(3'd1, 16'h0bee, 16'h0003, 1'b1);
        settle();

        QueryAddr = 3'd4;
        alu(3'd4, 16'h0011, 16'h0, 1'b0);
        cyc();
        alu(3'd4, 16'h0022, 16'h0, 1'b0);
        settle();

        QueryAddr = 3'd7;
        alu(3'd2, 16'h0202, 16'h0055, 1'b1);
        cyc();
        alu(3'd7, 16'h7777, 16'h0, 1'b0);
        settle();

        for (int i = 0; i < 8; i++) begin
            mem(3'(i), 16'(16'hA000 + i));
            cyc();
        end
        settle();

        mem(3'd6, 16'h6666);
        cyc();
        Reset_n = 1'b0;
        mem(3'd2, 16'h0002);
        alu(3'd3, 16'h0003, 16'h0, 1'b0);
        cyc();
        Reset_n = 1'b1;
        MemValid = 1'b0;
        AluValid = 1'b0;
        repeat (2) cyc();

        for (int c = 0; c < 400; c++) begin
            if (!MemValid && $urandom_range(0, 2) == 0)
                mem(3'($urandom_range(0, 7)), 16'($urandom));
            if (!AluValid && $urandom_range(0, 1) == 0)
                alu(3'($urandom_range(0, 7)), 16'($urandom),
                    16'($urandom), 1'($urandom_range(0, 1)));
            QueryAddr = 3'($urandom_range(0, 7));
            Reset_n = ($urandom_range(0, 99) != 0);
            cyc();
        end
        Reset_n = 1'b1;
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL have parameter DEPTH, 4, number of queued write-back entries (power of two, 2..16).
REQ-002 The block SHALL have parameter FLAGS_ADDR, 7, register address that holds the flags word.
REQ-003 The block SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset_n  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port AluValid / AluReady  input / output  1 / 1  ALU result handshake.
REQ-006 The block SHALL have port AluAddr / AluData / AluFlags / AluUpdFlags  input  3 / 16 / 16 / 1  ALU destination, result, new flags, flags-update request.
REQ-007 The block SHALL have port MemValid / MemReady  input / output  1 / 1  load-result handshake.
REQ-008 The block SHALL have port MemAddr / MemData  input  3 / 16  load destination and data; loads never update flags.
REQ-009 The block SHALL have port WrEn / WrAddr / WrData  output  1 / 3 / 16  register-file write port.
REQ-010 The block SHALL have port WrFlags / WrUpdFlags  output  16 / 1  flags word and flags-write enable for the register file.
REQ-011 The block SHALL have port Busy  output  8  bit i set while any queued entry targets register i.
REQ-012 The block SHALL have port QueryAddr / FwdHit / FwdData  input / output / output  3 / 1 / 16  forwarding lookup (see Configuration).

Function
REQ-013 Accepted results SHALL be stored in a DEPTH-entry FIFO of {addr, data, flags, updflags}; at most one push per cycle.
REQ-014 A transfer SHALL occur on a rising edge where Valid and Ready are both 1; Valid/payload held stable by source until accepted.
REQ-015 MemReady SHALL equal !full; AluReady SHALL equal !full && !MemValid (loads have fixed priority).
REQ-016 Ready SHALL depend on full only, not on a same-cycle pop; no push while full.
REQ-017 WrEn SHALL equal !empty; WrAddr/WrData/WrFlags SHALL present the FIFO head combinationally; WrUpdFlags SHALL equal !empty && head.updflags.
REQ-018 The head SHALL be popped on every rising edge where WrEn=1 (register file always accepts).
REQ-019 Latency: result accepted at edge N into an empty FIFO SHALL appear on Wr* during cycle N..N+1 and be written at edge N+1.
REQ-020 Simultaneous push and pop SHALL keep occupancy unchanged; pointers SHALL wrap modulo DEPTH.
REQ-021 Busy SHALL be computed from per-register pending counters (width clog2(DEPTH+1)) incremented on push, decremented on pop of that address; same-address push and pop in one cycle leaves count unchanged.
REQ-022 Busy[FLAGS_ADDR] SHALL additionally be 1 while any queued entry has updflags=1.

Reset
REQ-023 With Reset_n=0 at a rising edge the FIFO SHALL empty, pointers and counters SHALL clear; thereafter WrEn=0, WrUpdFlags=0, Busy=0, FwdHit=0, FwdData=0, MemReady=1, AluReady=!MemValid.
REQ-024 Reset mid-operation SHALL discard all queued entries without issuing writes; handshakes during the reset cycle SHALL be ignored.

Configuration
REQ-025 Macro REG_WRITEBACK_FWD_EN SHALL compile in forwarding: FwdHit=1 when any queued entry targets QueryAddr, FwdData = data of the youngest such entry (flags word if QueryAddr=FLAGS_ADDR and youngest entry with updflags is youngest match); combinational.
REQ-026 Without REG_WRITEBACK_FWD_EN, FwdHit and FwdData SHALL be tied to 0 and no compare logic SHALL exist.

Structure
REQ-027 Package wb_pkg SHALL hold the entry struct type, REG_ADDR_W=3, DATA_W=16 and default FLAGS_ADDR=7.
REQ-028 The FIFO storage and pointers SHALL be sub-module wb_fifo; arbitration, counters and forwarding stay in reg_writeback.

Verification
REQ-029 Single ALU push addr=3 data=0x1234 into empty FIFO -> next cycle WrEn=1, WrAddr=3, WrData=0x1234, Busy=0x08; after pop Busy=0x00.
REQ-030 AluValid and MemValid both 1 (Alu addr 2, Mem addr 5) -> Mem accepted first, AluReady=0 that cycle; writes appear in order 5 then 2.
REQ-031 Fill DEPTH=4 with pushes while sink pops each cycle is stalled by back-to-back pushes -> MemReady=0 exactly when occupancy=4; no entry lost or duplicated across pointer wrap.
REQ-032 ALU push addr=1 with AluUpdFlags=1, AluFlags=0x0003 -> WrUpdFlags=1, WrFlags=0x0003, Busy[7]=1 until popped.
REQ-033 With REG_WRITEBACK_FWD_EN: queue addr 4 data 0x0011 then addr 4 data 0x0022, QueryAddr=4 -> FwdHit=1, FwdData=0x0022; without macro -> FwdHit=0.
REQ-034 Assert Reset_n=0 with 3 entries queued -> next cycle WrEn=0, Busy=0x00, no write issued.
